// File: rtl/shader_alu_stage.sv
// Two-stage elastic shader ALU: S1 latches operands and lane products,
// S2 latches the final add/sub, wrap flags and drives the result beat.
module shader_alu_stage #(
    parameter int WIDTH = 32,
    parameter int LANES = 4,
    localparam int VEC_W = WIDTH * LANES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             vec_mode,
    input  logic [WIDTH-1:0] a_s,
    input  logic [WIDTH-1:0] b_s,
    input  logic [WIDTH-1:0] c_s,
    input  logic [VEC_W-1:0] a_v,
    input  logic [VEC_W-1:0] b_v,
    input  logic [VEC_W-1:0] c_v,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_s,
    output logic [VEC_W-1:0] res_v,
    output logic             res_vec,
    output logic [LANES-1:0] res_wrap,
    output logic [15:0]      beat_cnt
);

    logic                        s1_valid_q, s1_valid_d;
    logic                        s1_sub_q, s1_sub_d;
    logic                        s1_vec_q, s1_vec_d;
    logic [LANES-1:0][WIDTH-1:0] s1_x_q, s1_x_d;
    logic [LANES-1:0][WIDTH-1:0] s1_y_q, s1_y_d;
    logic [LANES-1:0]            s1_ovf_q, s1_ovf_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] res_s_q, res_s_d;
    logic [VEC_W-1:0] res_v_q, res_v_d;
    logic             res_vec_q, res_vec_d;
    logic [LANES-1:0] res_wrap_q, res_wrap_d;
    logic [15:0]      beat_cnt_q, beat_cnt_d;

    logic [LANES-1:0][WIDTH-1:0]   a_l, b_l, c_l;
    logic [LANES-1:0][WIDTH-1:0]   x_in, y_in;
    logic [LANES-1:0][2*WIDTH-1:0] prod;
    logic [LANES-1:0]              ovf_in;
    logic [LANES-1:0][WIDTH:0]     sum;
    logic [LANES-1:0]              wrap_l;
    logic [VEC_W-1:0]              vec_res;

    logic s1_load, s2_load, accept, fire_out;
    logic [LANES-1:0] wrap_mask;

    // Scalar operands ride in lane 0; the other lanes see zeros.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        if (i == 0) begin : g_l0
            assign a_l[i] = vec_mode ? a_v[i*WIDTH +: WIDTH] : a_s;
            assign b_l[i] = vec_mode ? b_v[i*WIDTH +: WIDTH] : b_s;
            assign c_l[i] = vec_mode ? c_v[i*WIDTH +: WIDTH] : c_s;
        end else begin : g_ln
            assign a_l[i] = vec_mode ? a_v[i*WIDTH +: WIDTH] : '0;
            assign b_l[i] = vec_mode ? b_v[i*WIDTH +: WIDTH] : '0;
            assign c_l[i] = vec_mode ? c_v[i*WIDTH +: WIDTH] : '0;
        end
        assign prod[i] = {{WIDTH{1'b0}}, a_l[i]}
                       * {{WIDTH{1'b0}}, b_l[i]};
        assign x_in[i] = op[1] ? prod[i][WIDTH-1:0] : a_l[i];
        assign y_in[i] = (op == 2'b10) ? '0
                       : (op == 2'b11) ? c_l[i] : b_l[i];
        assign ovf_in[i] = op[1]
                         && (prod[i][2*WIDTH-1:WIDTH] != '0);
        assign sum[i] = s1_sub_q
            ? ({1'b0, s1_x_q[i]} - {1'b0, s1_y_q[i]})
            : ({1'b0, s1_x_q[i]} + {1'b0, s1_y_q[i]});
        assign wrap_l[i] = s1_ovf_q[i] | sum[i][WIDTH];
        assign vec_res[i*WIDTH +: WIDTH] = sum[i][WIDTH-1:0];
    end

    assign in_ready = !rst
        && (!s1_valid_q || !s2_valid_q || out_ready);

    always_comb begin
        s2_load   = !s2_valid_q || out_ready;
        s1_load   = !s1_valid_q || s2_load;
        accept    = in_valid && in_ready;
        fire_out  = s2_valid_q && out_ready;
        wrap_mask = s1_vec_q ? '1 : LANES'(1);

        s1_valid_d = s1_valid_q;
        s1_sub_d   = s1_sub_q;
        s1_vec_d   = s1_vec_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s1_ovf_d   = s1_ovf_q;
        s2_valid_d = s2_valid_q;
        res_s_d    = res_s_q;
        res_v_d    = res_v_q;
        res_vec_d  = res_vec_q;
        res_wrap_d = res_wrap_q;
        beat_cnt_d = beat_cnt_q;

        if (s1_load) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_sub_d = (op == 2'b01);
                s1_vec_d = vec_mode;
                s1_x_d   = x_in;
                s1_y_d   = y_in;
                s1_ovf_d = ovf_in;
            end
        end

        // Result registers only move when a new beat replaces them.
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_s_d    = s1_vec_q ? '0 : sum[0][WIDTH-1:0];
                res_v_d    = s1_vec_q ? vec_res : '0;
                res_vec_d  = s1_vec_q;
                res_wrap_d = wrap_l & wrap_mask;
            end
        end

        if (fire_out) begin
            beat_cnt_d = beat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sub_q   <= 1'b0;
            s1_vec_q   <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_ovf_q   <= '0;
            s2_valid_q <= 1'b0;
            res_s_q    <= '0;
            res_v_q    <= '0;
            res_vec_q  <= 1'b0;
            res_wrap_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sub_q   <= s1_sub_d;
            s1_vec_q   <= s1_vec_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s1_ovf_q   <= s1_ovf_d;
            s2_valid_q <= s2_valid_d;
            res_s_q    <= res_s_d;
            res_v_q    <= res_v_d;
            res_vec_q  <= res_vec_d;
            res_wrap_q <= res_wrap_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign res_s     = res_s_q;
    assign res_v     = res_v_q;
    assign res_vec   = res_vec_q;
    assign res_wrap  = res_wrap_q;
    assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_shader_alu_stage.sv
// Scoreboard bench for shader_alu_stage: a lane model predicts each
// accepted beat, results are popped and compared as they are delivered.
module tb_shader_alu_stage;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   op = 2'b00;
    logic         vec_mode = 1'b0;
    logic [31:0]  a_s = '0, b_s = '0, c_s = '0;
    logic [127:0] a_v = '0, b_v = '0, c_v = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [31:0]  res_s;
    logic [127:0] res_v;
    logic         res_vec;
    logic [3:0]   res_wrap;
    logic [15:0]  beat_cnt;

    shader_alu_stage #(.WIDTH(32), .LANES(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .vec_mode(vec_mode),
        .a_s(a_s), .b_s(b_s), .c_s(c_s),
        .a_v(a_v), .b_v(b_v), .c_v(c_v),
        .out_valid(out_valid), .out_ready(out_ready),
        .res_s(res_s), .res_v(res_v), .res_vec(res_vec),
        .res_wrap(res_wrap), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         vec;
        logic [31:0]  s;
        logic [127:0] v;
        logic [3:0]   w;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   rdy_mode = 0;
    int   pat_i = 0;

    logic [31:0] last_s;
    logic [127:0] last_v;
    logic [3:0]  last_w;
    logic        last_vec;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Exact per-lane arithmetic, then truncate and flag out-of-range.
    function automatic exp_t model(input logic [1:0] o, input logic v,
                                   input logic [127:0] a,
                                   input logic [127:0] b,
                                   input logic [127:0] c);
        exp_t e;
        e.vec = v; e.s = '0; e.v = '0; e.w = '0;
        for (int l = 0; l < 4; l++) begin
            bit [63:0] x, y, z, p, t, ex;
            bit wr;
            if (!v && l > 0) break;
            x = 64'(a[l*32 +: 32]);
            y = 64'(b[l*32 +: 32]);
            z = 64'(c[l*32 +: 32]);
            p = x * y;
            t = 64'(p[31:0]) + z;
            case (o)
                2'b00: begin ex = x + y; wr = ex[32]; end
                2'b01: begin ex = x - y; wr = (x < y); end
                2'b10: begin ex = p; wr = (p[63:32] != 0); end
                default: begin
                    ex = t; wr = (p[63:32] != 0) || t[32];
                end
            endcase
            if (v) e.v[l*32 +: 32] = ex[31:0];
            else   e.s = ex[31:0];
            e.w[l] = wr;
        end
        return e;
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 3))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [127:0] rndv();
        return {rnd32(), rnd32(), rnd32(), rnd32()};
    endfunction

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            2: begin out_ready = (pat_i % 3 == 0); pat_i++; end
            default: out_ready = 1'b0;
        endcase
    end

    logic         hold_v = 1'b0;
    logic [127:0] hold_rv;
    logic [36:0]  hold_sw;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_res_v", res_v, hold_rv);
                chk("hold_res_s", {res_vec, res_wrap, res_s}, hold_sw);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_beat", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    chk("res_s", res_s, e.s);
                    chk("res_v", res_v, e.v);
                    chk("res_wrap", res_wrap, e.w);
                    chk("res_vec", res_vec, e.vec);
                    last_s = res_s; last_v = res_v;
                    last_w = res_wrap; last_vec = res_vec;
                end
            end
            hold_v  = out_valid && !out_ready;
            hold_rv = res_v;
            hold_sw = {res_vec, res_wrap, res_s};
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [1:0] o, input logic v,
                        input logic [127:0] a, input logic [127:0] b,
                        input logic [127:0] c);
        op = o; vec_mode = v;
        if (v) begin
            a_v = a; b_v = b; c_v = c;
            a_s = $urandom; b_s = $urandom; c_s = $urandom;
        end else begin
            a_s = a[31:0]; b_s = b[31:0]; c_s = c[31:0];
            a_v = {$urandom, $urandom, $urandom, $urandom};
            b_v = {$urandom, $urandom, $urandom, $urandom};
            c_v = {$urandom, $urandom, $urandom, $urandom};
        end
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(o, v, a, b, c));
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((sb.size() != 0 || out_valid) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("drain_empty", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [15:0] cnt0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_beat_cnt", beat_cnt, 0);
        chk("rst_res_s", res_s, 0);
        chk("rst_res_v", res_v, 0);
        chk("rst_res_wrap", res_wrap, 0);
        chk("rst_res_vec", res_vec, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        send(2'b00, 1'b0, 128'hFFFF_FFFF, 128'd2, 128'd0);
        drain();
        chk("add_res_s", last_s, 32'h1);
        chk("add_res_wrap", last_w, 4'b0001);
        chk("add_res_vec", last_vec, 0);

        send(2'b11, 1'b1,
             {32'h10000, 32'd3, 32'd2, 32'd1},
             {32'h10000, 32'd6, 32'd5, 32'd4},
             {32'd1, 32'd10, 32'd10, 32'd10});
        drain();
        chk("mac_res_v", last_v, {32'd1, 32'd28, 32'd20, 32'd14});
        chk("mac_res_wrap", last_w, 4'b1000);
        chk("mac_res_vec", last_vec, 1);

        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            send(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 rndv(), rndv(), rndv());
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        rdy_mode = 0;
        drain();

        rdy_mode = 2; pat_i = 0;
        idle(1);
        cnt0 = beat_cnt;
        for (int i = 0; i < 8; i++) begin
            send(2'b01, 1'b1, {4{32'(i)}}, rndv(), rndv());
        end
        rdy_mode = 0;
        drain();
        @(negedge clk);
        chk("sub8_beat_cnt", beat_cnt, cnt0 + 16'd8);
        @(posedge clk); #1;

        rdy_mode = 3;
        idle(2);
        send(2'b10, 1'b0, rndv(), rndv(), rndv());
        send(2'b00, 1'b1, rndv(), rndv(), rndv());
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        @(posedge clk); #1;
        op = 2'b11; vec_mode = 1'b1; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            @(posedge clk); #1;
            a_s = $urandom;
            a_v = {$urandom, $urandom, $urandom, $urandom};
        end
        in_valid = 1'b0;
        rdy_mode = 0;
        drain();
        @(negedge clk);
        chk("drained_in_ready", in_ready, 1);
        @(posedge clk); #1;

        rdy_mode = 3;
        idle(2);
        send(2'b00, 1'b0, rndv(), rndv(), rndv());
        send(2'b11, 1'b1, rndv(), rndv(), rndv());
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        rdy_mode = 0;
        @(negedge clk);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_beat_cnt", beat_cnt, 0);
        chk("flush_in_ready", in_ready, 1);
        repeat (5) begin
            @(negedge clk);
            chk("flush_quiet", out_valid, 0);
        end
        @(posedge clk); #1;

        for (int i = 0; i < 65535; i++) begin
            send(2'b00, 1'b0, rndv(), rndv(), rndv());
        end
        drain();
        @(negedge clk);
        chk("cnt_ffff", beat_cnt, 16'hFFFF);
        @(posedge clk); #1;
        send(2'b01, 1'b0, rndv(), rndv(), rndv());
        drain();
        @(negedge clk);
        chk("cnt_wrap", beat_cnt, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_cmp, n_err);
        $finish;
    end

endmodule
